// File: rtl/led_share_arbiter_if.sv
// Bundle between the LED display sources and the LED arbiter.
// Ports: req/data come from the sources (master side); led/grant/busy
//        go back from the arbiter (slave side) toward the pins and sources.
interface led_share_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req;    // per-source level request, bit i = source i
   logic [16*N_REQ-1:0] data;   // source i word in data[16*i +: 16]
   logic [15:0]         led;    // registered LED drive
   logic [N_REQ-1:0]    grant;  // registered one-hot grant, zero when idle
   logic                busy;   // registered, equals |grant

   modport master (
      output req,
      output data,
      input  led,
      input  grant,
      input  busy
   );

   modport slave (
      input  req,
      input  data,
      output led,
      output grant,
      output busy
   );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin time-share of the 16 user LEDs between N_REQ display sources,
// each winner holding the LEDs for DWELL cycles; grant/led one edge after req.
// No backpressure: req is level-sensitive, a source drops req to release early.
// Ports: clk, rst (sync, active-high); bus.slave carries req/data in and
//        led/grant/busy out, all outputs registered.
module led_share_arbiter #(
   parameter int          N_REQ        = 4,
   parameter int          DWELL        = 100_000_000,
   parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
   input logic                clk,
   input logic                rst,
   led_share_arbiter_if.slave bus
);

   localparam int             IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int             CW       = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
   localparam logic [CW-1:0]  RELOAD   = CW'(DWELL - 1);
   localparam logic [IW-1:0]  LAST_RST = IW'(N_REQ - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    last;      // most recent winner; also the current grantee in HOLD
   logic [N_REQ-1:0] grant_q;
   logic             busy_q;
   logic [15:0]      led_q;

   // Per-source views of the flat data bus.
   logic [15:0] slice [N_REQ];
   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign slice[i] = bus.data[16*i +: 16];
   end

   // Round-robin search: first set req bit starting at last+1, wrapping.
   logic             win_found;
   logic [IW-1:0]    win_idx;
   logic [N_REQ-1:0] win_onehot;
   logic [IW-1:0]    cand;

   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      cand       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IW'((int'(last) + k) % N_REQ);
         if (!win_found && bus.req[cand]) begin
            win_found        = 1'b1;
            win_idx          = cand;
            win_onehot[cand] = 1'b1;
         end
      end
   end

   // Re-arbitrate when idle, when the dwell ran out, or when the grantee
   // let go of its request. A sole requester at expiry simply re-wins,
   // so grant stays steady with no gap.
   logic arb_evt;
   assign arb_evt = (state == IDLE) || (cnt == '0) || !bus.req[last];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         last    <= LAST_RST;
         grant_q <= '0;
         busy_q  <= 1'b0;
         led_q   <= IDLE_PATTERN;
      end else if (arb_evt) begin
         if (win_found) begin
            state   <= HOLD;
            cnt     <= RELOAD;
            last    <= win_idx;
            grant_q <= win_onehot;
            busy_q  <= 1'b1;
            led_q   <= slice[win_idx];
         end else begin
            state   <= IDLE;
            cnt     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            led_q   <= IDLE_PATTERN;
         end
      end else begin
         // cnt is nonzero here, so the decrement never wraps.
         cnt   <= cnt - 1'b1;
         led_q <= slice[last];
      end
   end

   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;
   assign bus.led   = led_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
module tb_led_share_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   led_share_arbiter_if #(.N_REQ(4)) bus ();

   led_share_arbiter #(
      .N_REQ       (4),
      .DWELL       (4),
      .IDLE_PATTERN(16'h0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [3:0] g, input logic b, input logic [15:0] l);
      chk({tag, ".grant"}, {12'h000, bus.grant}, {12'h000, g});
      chk({tag, ".busy"},  {15'h0000, bus.busy}, {15'h0000, b});
      chk({tag, ".led"},   bus.led, l);
   endtask

   task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3);
      bus.data = {d3, d2, d1, d0};
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.req  = 4'b1111;
      set_data(16'h0001, 16'h0002, 16'h0004, 16'h0008);

      // Reset dominates requests.
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_state($sformatf("reset%0d", i), 4'b0000, 1'b0, 16'h0000);
      end

      // Single source 2, continuous across three dwell expiries.
      rst     = 1'b0;
      bus.req = 4'b0100;
      set_data(16'h0001, 16'h0002, 16'hA5A5, 16'h0008);
      tick();
      chk_state("single_first", 4'b0100, 1'b1, 16'hA5A5);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk_state($sformatf("single_hold%0d", i), 4'b0100, 1'b1, 16'hA5A5);
      end

      // Drop to idle, then reset so source 0 has first priority again.
      bus.req = 4'b0000;
      tick();
      chk_state("idle_after_single", 4'b0000, 1'b0, 16'h0000);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Round robin, each grant exactly 4 cycles, gapless.
      set_data(16'h0001, 16'h0002, 16'h0004, 16'h0008);
      bus.req = 4'b1111;
      for (int c = 0; c <= 16; c++) begin
         tick();
         chk_state($sformatf("rr_c%0d", c), 4'(1 << ((c / 4) % 4)), 1'b1,
                   16'(1 << ((c / 4) % 4)));
      end

      // Source 0 is now in its first dwell cycle; release it to hand to source 1.
      bus.req = 4'b0010;
      tick();
      chk_state("er_grant1_c1", 4'b0010, 1'b1, 16'h0002);
      tick();
      chk_state("er_grant1_c2", 4'b0010, 1'b1, 16'h0002);
      bus.req = 4'b1000;
      tick();
      chk_state("er_handover", 4'b1000, 1'b1, 16'h0008);
      bus.req = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_state($sformatf("er_full_dwell%0d", i), 4'b1000, 1'b1, 16'h0008);
      end
      tick();
      chk_state("er_next_src0", 4'b0001, 1'b1, 16'h0001);

      // Data tracking on source 3.
      set_data(16'h0001, 16'h0002, 16'h0004, 16'h1234);
      bus.req = 4'b1000;
      tick();
      chk_state("track_grant3", 4'b1000, 1'b1, 16'h1234);
      set_data(16'h0001, 16'h0002, 16'h0004, 16'hBEEF);
      tick();
      chk_state("track_beef", 4'b1000, 1'b1, 16'hBEEF);
      set_data(16'hFFFF, 16'h0002, 16'h0004, 16'hBEEF);
      tick();
      chk_state("track_ignore_d0", 4'b1000, 1'b1, 16'hBEEF);
      bus.req = 4'b0000;
      tick();
      chk_state("track_idle", 4'b0000, 1'b0, 16'h0000);

      // Reset in the middle of a source-2 grant.
      bus.req = 4'b0100;
      tick();
      chk_state("mid_grant2", 4'b0100, 1'b1, 16'h0004);
      bus.req = 4'b0101;
      tick();
      chk_state("mid_grant2_hold", 4'b0100, 1'b1, 16'h0004);
      rst = 1'b1;
      tick();
      chk_state("mid_reset", 4'b0000, 1'b0, 16'h0000);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_state($sformatf("post_rst_src0_%0d", i), 4'b0001, 1'b1, 16'hFFFF);
      end
      tick();
      chk_state("post_rst_src2", 4'b0100, 1'b1, 16'h0004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
